// File: rtl/dot_driver_array_if.sv
// dot_driver_array_if
//   Groups the sequencer-to-driver signals of dot_driver_array into one bundle.
//
//   Parameters:
//     NUM_DOTS : number of independent channels
//     CNT_W    : width of the pulse-length and dead-time values
//
//   master modport (sequencer core side):
//     drives  dot_enable, output_enable, dot_state, dot_invert, fire,
//             pulse_len, dead_len
//     samples data, enable, busy, done
//   slave modport (driver array side): the same signals, opposite directions.
interface dot_driver_array_if #(
    parameter int NUM_DOTS = 8,
    parameter int CNT_W    = 12
);
    logic [NUM_DOTS-1:0] dot_enable;
    logic                output_enable;
    logic [NUM_DOTS-1:0] dot_state;
    logic [NUM_DOTS-1:0] dot_invert;
    logic [NUM_DOTS-1:0] fire;
    logic [CNT_W-1:0]    pulse_len;
    logic [CNT_W-1:0]    dead_len;
    logic [NUM_DOTS-1:0] data;
    logic [NUM_DOTS-1:0] enable;
    logic [NUM_DOTS-1:0] busy;
    logic [NUM_DOTS-1:0] done;

    modport master (
        output dot_enable, output_enable, dot_state, dot_invert, fire,
               pulse_len, dead_len,
        input  data, enable, busy, done
    );

    modport slave (
        input  dot_enable, output_enable, dot_state, dot_invert, fire,
               pulse_len, dead_len,
        output data, enable, busy, done
    );
endinterface

// File: rtl/dot_driver_array.sv
// dot_driver_array
//   Multi-channel micro-motor dot driver. Each channel drives a registered
//   polarity line (data) and a timed drive-enable pulse (enable) of
//   pulse_len cycles, started by a one-cycle fire strobe. With the optional
//   dead-time feature, a polarity reversal first spends dead_len cycles with
//   enable held low, so the H-bridge never changes polarity while enabled.
//
//   Compile-time option:
//     DOT_DRIVER_DEADTIME_EN : when defined, the DEAD state and dead-time
//                              logic are built; otherwise dead_len is ignored
//                              and every accepted fire goes straight to DRIVE.
//
//   Ports:
//     clock : rising-edge clock for every register
//     reset : synchronous, active-high reset
//     bus   : dot_driver_array_if.slave
//             in  dot_enable[N], output_enable, dot_state[N], dot_invert[N],
//                 fire[N], pulse_len[CNT_W], dead_len[CNT_W]
//             out data[N], enable[N], busy[N], done[N]
module dot_driver_array #(
    parameter int NUM_DOTS = 8,
    parameter int CNT_W    = 12
) (
    input  logic               clock,
    input  logic               reset,
    dot_driver_array_if.slave  bus
);

`ifdef DOT_DRIVER_DEADTIME_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DEAD = 2'd1, DRIVE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd2} state_t;
`endif

    // Counters never wrap: decrementing an empty counter leaves it at zero.
    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    state_t              state_q [NUM_DOTS];
    state_t              state_d [NUM_DOTS];
    logic [CNT_W-1:0]    cnt_q   [NUM_DOTS];
    logic [CNT_W-1:0]    cnt_d   [NUM_DOTS];
`ifdef DOT_DRIVER_DEADTIME_EN
    // Pulse length and target are held across the dead interval.
    logic [CNT_W-1:0]    plen_q  [NUM_DOTS];
    logic [CNT_W-1:0]    plen_d  [NUM_DOTS];
    logic [NUM_DOTS-1:0] tgt_q;
    logic [NUM_DOTS-1:0] tgt_d;
    logic [NUM_DOTS-1:0] need_dead;
`endif

    logic [NUM_DOTS-1:0] data_q;
    logic [NUM_DOTS-1:0] data_d;
    logic [NUM_DOTS-1:0] enable_q;
    logic [NUM_DOTS-1:0] enable_d;
    logic [NUM_DOTS-1:0] done_q;
    logic [NUM_DOTS-1:0] done_d;

    logic [NUM_DOTS-1:0] idle;
    logic [NUM_DOTS-1:0] cnt_one;
    logic [NUM_DOTS-1:0] tgt_in;
    logic [NUM_DOTS-1:0] accept;
    logic                len_ok;

    assign tgt_in = bus.dot_state ^ bus.dot_invert;
    assign len_ok = (bus.pulse_len != '0);

    for (genvar g = 0; g < NUM_DOTS; g++) begin : g_dec
        assign idle[g]    = (state_q[g] == IDLE);
        assign cnt_one[g] = (cnt_q[g] == CNT_W'(1));
    end

    // A zero pulse length makes the strobe invisible: no state change at all.
    assign accept = bus.fire & bus.dot_enable & idle & {NUM_DOTS{len_ok}};

`ifdef DOT_DRIVER_DEADTIME_EN
    // Dead time is only inserted when the polarity actually reverses.
    assign need_dead = (tgt_in ^ data_q) & {NUM_DOTS{bus.dead_len != '0}};
`else
    logic unused_dead_len;
    assign unused_dead_len = ^bus.dead_len;
`endif

    // ---- next-state logic ----
    always_comb begin
        for (int i = 0; i < NUM_DOTS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
`ifdef DOT_DRIVER_DEADTIME_EN
            plen_d[i]  = plen_q[i];
            tgt_d[i]   = tgt_q[i];
`endif
            case (state_q[i])
                IDLE: begin
                    if (accept[i]) begin
                        state_d[i] = DRIVE;
                        cnt_d[i]   = bus.pulse_len;
`ifdef DOT_DRIVER_DEADTIME_EN
                        plen_d[i]  = bus.pulse_len;
                        tgt_d[i]   = tgt_in[i];
                        if (need_dead[i]) begin
                            state_d[i] = DEAD;
                            cnt_d[i]   = bus.dead_len;
                        end
`endif
                    end
                end
`ifdef DOT_DRIVER_DEADTIME_EN
                DEAD: begin
                    if (!bus.dot_enable[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_one[i]) begin
                        state_d[i] = DRIVE;
                        cnt_d[i]   = plen_q[i];
                    end else begin
                        cnt_d[i]   = cnt_dec(cnt_q[i]);
                    end
                end
`endif
                DRIVE: begin
                    // Abort wins over completion: no done on an aborted pulse.
                    if (!bus.dot_enable[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_one[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = cnt_dec(cnt_q[i]);
                    end else begin
                        cnt_d[i]   = cnt_dec(cnt_q[i]);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // ---- output logic (values registered on the next edge) ----
    always_comb begin
        data_d   = data_q;
        enable_d = '0;
        done_d   = '0;
        for (int i = 0; i < NUM_DOTS; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (accept[i]) begin
                        // dot_enable is known high here, so only the mask matters.
                        data_d[i]   = tgt_in[i];
                        enable_d[i] = bus.output_enable;
`ifdef DOT_DRIVER_DEADTIME_EN
                        if (need_dead[i]) begin
                            data_d[i]   = data_q[i];
                            enable_d[i] = 1'b0;
                        end
`endif
                    end
                end
`ifdef DOT_DRIVER_DEADTIME_EN
                DEAD: begin
                    if (bus.dot_enable[i] && cnt_one[i]) begin
                        data_d[i]   = tgt_q[i];
                        enable_d[i] = bus.output_enable;
                    end
                end
`endif
                DRIVE: begin
                    if (bus.dot_enable[i]) begin
                        if (cnt_one[i]) begin
                            done_d[i]   = 1'b1;
                        end else begin
                            enable_d[i] = bus.output_enable;
                        end
                    end
                end
                default: begin
                    enable_d[i] = 1'b0;
                end
            endcase
        end
    end

    // ---- state / output register stage ----
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_DOTS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
`ifdef DOT_DRIVER_DEADTIME_EN
                plen_q[i]  <= '0;
`endif
            end
`ifdef DOT_DRIVER_DEADTIME_EN
            tgt_q    <= '0;
`endif
            data_q   <= '0;
            enable_q <= '0;
            done_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_DOTS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef DOT_DRIVER_DEADTIME_EN
                plen_q[i]  <= plen_d[i];
`endif
            end
`ifdef DOT_DRIVER_DEADTIME_EN
            tgt_q    <= tgt_d;
`endif
            data_q   <= data_d;
            enable_q <= enable_d;
            done_q   <= done_d;
        end
    end

    assign bus.data   = data_q;
    assign bus.enable = enable_q;
    assign bus.done   = done_q;
    assign bus.busy   = ~idle;

endmodule
